arm_ldst_seq: RTL and testbench
===============================

Name: arm_ldst_seq

Overview:
Parametrised multi-cycle load/store sequencer for the ARM core. It decodes single-word LDR/STR with immediate offset and LDM/STM block transfers, then issues one memory micro-op per transferred register over a valid/ready handshake. It also produces the base-register writeback. It sits beside arm_decode: arm_decode steers data-processing and branch, and this block owns every instruction with inst[27:25] = 3'b010 or 3'b100.

Parameters:
ADDR_W, 32, width of base register value and micro-op address (arithmetic is modulo 2^ADDR_W)
NREGS, 16, register-list width taken from inst[NREGS-1:0]; legal range 2..16
REG_IDX_W, 4, register index width; must satisfy 2^REG_IDX_W >= NREGS

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous active-low reset
inst_valid  in  1  instruction offered
inst_ready  out  1  block can accept (high only in IDLE)
inst  in  32  instruction word
cond_pass  in  1  condition check result, sampled with inst
read_rn  out  4  combinational inst[19:16], drives register file read port
rn_val  in  ADDR_W  base register value, sampled at accept
uop_valid  out  1  micro-op valid
uop_ready  in  1  memory side accepts micro-op
uop_load  out  1  1 = load (L bit), 0 = store
uop_reg  out  REG_IDX_W  register transferred
uop_addr  out  ADDR_W  word address
uop_last  out  1  final micro-op of the instruction
wb_valid  out  1  one-cycle base writeback strobe (no backpressure)
wb_reg  out  REG_IDX_W  base register index
wb_data  out  ADDR_W  new base value
busy  out  1  state != IDLE

Behaviour:
- Clock and reset: one clock clk; reset rst_n is synchronous and active-low. While rst_n=0 at a clk edge: state=IDLE; uop_valid, uop_load, uop_reg, uop_addr, uop_last, wb_valid, wb_reg, wb_data and busy all clear to 0. inst_ready is 1 after reset.
- Reset mid-operation abandons the instruction. No further uops are issued and no writeback occurs.
- FSM states: IDLE, ISSUE, WB. inst_ready = (state == IDLE). All uop_* and wb_* outputs are registered.
- Accept in IDLE happens when inst_valid=1. At accept, the block latches inst fields and rn_val. The next state is chosen as follows:
  - cond_pass=0, or inst[27:25] not in {010, 100}: the instruction is consumed and dropped. Stay in IDLE; no uop, no wb.
  - LDM/STM with an empty register list: consumed. Stay in IDLE; no uop, no wb.
  - Otherwise go to ISSUE. The first uop is valid the cycle after accept (latency 1).
- Single LDR/STR (P=inst[24], U=inst[23], W=inst[21], L=inst[20], imm=inst[11:0]; the B bit is ignored and the transfer is treated as a word):
  - off = U ? rn+imm : rn-imm.
  - uop_addr = P ? off : rn.
  - One uop, with uop_last=1 and uop_reg = inst[15:12].
  - Writeback is required when (!P || W), with wb_data = off.
- LDM/STM (the S bit is ignored):
  - list = inst[NREGS-1:0]; cnt = popcount(list).
  - Start address:
    - IA (P=0,U=1): rn
    - IB (P=1,U=1): rn+4
    - DA (P=0,U=0): rn-4*cnt+4
    - DB (P=1,U=0): rn-4*cnt
  - Registers are issued in ascending index order. Each accepted uop advances uop_addr by 4.
  - Writeback is required when W=1, with wb_data = U ? rn+4*cnt : rn-4*cnt.
  - Writeback is suppressed when L=1 and the base register is in list (the loaded value wins).
- ISSUE: uop_valid=1. While uop_ready=0, every uop_* output holds stable.
  - On uop_valid & uop_ready: clear the lowest set bit of the remaining list and present the next register/address the following cycle (one uop per cycle at full throughput).
  - uop_last=1 exactly when one bit remains.
  - When the last uop is accepted: go to WB if writeback is required, else to IDLE.
- WB: wb_valid=1 for exactly one cycle, with wb_reg = latched rn index and wb_data as above. The next state is IDLE.
- Address wrap-around is modulo 2^ADDR_W with no fault.
- Changes to inst/rn_val outside the accept cycle have no effect.

Test Plan:
- LDMIA r0!,{r1,r3,r5}, rn_val=0x1000 -> uops (load, reg1, 0x1000), (reg3, 0x1004), (reg5, 0x1008, last=1); then wb_valid with r0 = 0x100C; inst_ready high again the next cycle.
- STMDB r13!,{r4,r14}, rn_val=0x2000 -> store uops (reg4, 0x1FF8), (reg14, 0x1FFC, last); wb r13 = 0x1FF8. In the same run, hold uop_ready=0 for 3 cycles on the first uop -> all uop_* outputs stable and no address advance.
- LDR r2,[r1,#-8]! with rn=0x100 -> one uop at 0xF8, wb r1 = 0xF8. LDR r2,[r1],#8 -> uop at 0x100, wb 0x108. LDR r2,[r1,#4] -> uop at 0x104, no wb.
- cond_pass=0 on an LDM, and a data-processing inst with cond_pass=1 -> both accepted, no uop_valid, no wb_valid, busy stays 0.
- LDMDB r0,{r0,r1,r2}, rn=0x4, W=1 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0; no wb (base in list with load).
- Assert rst_n=0 after the first uop of a 4-register LDM is accepted -> all outputs 0 after the next edge, no wb, IDLE with inst_ready=1. Empty-list STM -> no activity.

Source files
------------

// File: rtl/arm_ldst_if.sv
// Load/store sequencer bus: instruction offer, register-file base read,
// memory micro-op channel and base writeback strobe.
interface arm_ldst_if #(
    parameter int ADDR_W    = 32,
    parameter int REG_IDX_W = 4
);
    logic                 inst_valid;
    logic                 inst_ready;
    logic [31:0]          inst;
    logic                 cond_pass;
    logic [3:0]           read_rn;
    logic [ADDR_W-1:0]    rn_val;
    logic                 uop_valid;
    logic                 uop_ready;
    logic                 uop_load;
    logic [REG_IDX_W-1:0] uop_reg;
    logic [ADDR_W-1:0]    uop_addr;
    logic                 uop_last;
    logic                 wb_valid;
    logic [REG_IDX_W-1:0] wb_reg;
    logic [ADDR_W-1:0]    wb_data;
    logic                 busy;

    modport master (
        output inst_valid, inst, cond_pass, rn_val, uop_ready,
        input  inst_ready, read_rn, uop_valid, uop_load, uop_reg, uop_addr,
               uop_last, wb_valid, wb_reg, wb_data, busy
    );

    modport slave (
        input  inst_valid, inst, cond_pass, rn_val, uop_ready,
        output inst_ready, read_rn, uop_valid, uop_load, uop_reg, uop_addr,
               uop_last, wb_valid, wb_reg, wb_data, busy
    );
endinterface

// File: rtl/arm_ldst_seq.sv
// Multi-cycle LDR/STR and LDM/STM sequencer: one memory micro-op per
// transferred register, followed by an optional base-register writeback.
module arm_ldst_seq #(
    parameter int ADDR_W    = 32,
    parameter int NREGS     = 16,
    parameter int REG_IDX_W = 4
) (
    input logic      clk,
    input logic      rst_n,
    arm_ldst_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WB = 2'd2} state_t;

    localparam logic [ADDR_W-1:0] WORD_BYTES = {{(ADDR_W-3){1'b0}}, 3'b100};
    localparam logic [NREGS-1:0]  LIST_ONE   = {{(NREGS-1){1'b0}}, 1'b1};

    function automatic logic [ADDR_W-1:0] pop_count(input logic [NREGS-1:0] v);
        logic [ADDR_W-1:0] c;
        c = {ADDR_W{1'b0}};
        for (int i = 0; i < NREGS; i++) c = c + {{(ADDR_W-1){1'b0}}, v[i]};
        return c;
    endfunction

    function automatic logic [REG_IDX_W-1:0] lowest_idx(input logic [NREGS-1:0] v);
        logic [REG_IDX_W-1:0] idx;
        idx = {REG_IDX_W{1'b0}};
        for (int i = NREGS - 1; i >= 0; i--) if (v[i]) idx = REG_IDX_W'(i);
        return idx;
    endfunction

    function automatic logic one_left(input logic [NREGS-1:0] v);
        return (v != {NREGS{1'b0}}) && ((v & (v - LIST_ONE)) == {NREGS{1'b0}});
    endfunction

    state_t               state_r, state_n;
    logic [NREGS-1:0]     rem_r, rem_n;
    logic                 wb_req_r, wb_req_n;
    logic                 uop_valid_r, uop_valid_n, uop_load_r, uop_load_n;
    logic                 uop_last_r, uop_last_n, wb_valid_r, wb_valid_n;
    logic [REG_IDX_W-1:0] uop_reg_r, uop_reg_n, wb_reg_r, wb_reg_n;
    logic [ADDR_W-1:0]    uop_addr_r, uop_addr_n, wb_data_r, wb_data_n;

    logic                 is_single_s, is_block_s, take_s, base_hit_s;
    logic [NREGS-1:0]     list_s, rem_next_s;
    logic [ADDR_W-1:0]    imm_s, cnt4_s, off_s, start_s, wbd_s;
    logic [REG_IDX_W-1:0] rn_idx_s;

    // Decode of the offered instruction: start address and writeback value.
    always_comb begin
        is_single_s = (bus.inst[27:25] == 3'b010);
        is_block_s  = (bus.inst[27:25] == 3'b100);
        list_s      = bus.inst[NREGS-1:0];
        rn_idx_s    = REG_IDX_W'(bus.inst[19:16]);
        imm_s       = {{(ADDR_W-12){1'b0}}, bus.inst[11:0]};
        cnt4_s      = pop_count(list_s) << 2;
        off_s       = bus.inst[23] ? (bus.rn_val + imm_s) : (bus.rn_val - imm_s);
        base_hit_s  = 1'b0;
        for (int i = 0; i < NREGS; i++)
            if (list_s[i] && (REG_IDX_W'(i) == rn_idx_s)) base_hit_s = 1'b1;
        if (is_single_s) begin
            start_s = bus.inst[24] ? off_s : bus.rn_val;
            wbd_s   = off_s;
        end else begin
            case ({bus.inst[24], bus.inst[23]})
                2'b01:   start_s = bus.rn_val;
                2'b11:   start_s = bus.rn_val + WORD_BYTES;
                2'b00:   start_s = bus.rn_val - cnt4_s + WORD_BYTES;
                default: start_s = bus.rn_val - cnt4_s;
            endcase
            wbd_s = bus.inst[23] ? (bus.rn_val + cnt4_s) : (bus.rn_val - cnt4_s);
        end
        take_s = bus.cond_pass &&
                 (is_single_s || (is_block_s && (list_s != {NREGS{1'b0}})));
    end

    // Next-state and next-output logic of the sequencer FSM.
    always_comb begin
        state_n     = state_r;
        rem_n       = rem_r;
        wb_req_n    = wb_req_r;
        uop_valid_n = uop_valid_r;
        uop_load_n  = uop_load_r;
        uop_reg_n   = uop_reg_r;
        uop_addr_n  = uop_addr_r;
        uop_last_n  = uop_last_r;
        wb_valid_n  = 1'b0;
        wb_reg_n    = wb_reg_r;
        wb_data_n   = wb_data_r;
        rem_next_s  = rem_r & (rem_r - LIST_ONE);
        case (state_r)
            IDLE: begin
                if (bus.inst_valid && take_s) begin
                    state_n     = ISSUE;
                    uop_valid_n = 1'b1;
                    uop_load_n  = bus.inst[20];
                    uop_addr_n  = start_s;
                    wb_reg_n    = rn_idx_s;
                    wb_data_n   = wbd_s;
                    if (is_single_s) begin
                        rem_n      = LIST_ONE;
                        uop_reg_n  = REG_IDX_W'(bus.inst[15:12]);
                        uop_last_n = 1'b1;
                        wb_req_n   = !bus.inst[24] || bus.inst[21];
                    end else begin
                        rem_n      = list_s;
                        uop_reg_n  = lowest_idx(list_s);
                        uop_last_n = one_left(list_s);
                        wb_req_n   = bus.inst[21] && !(bus.inst[20] && base_hit_s);
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            ISSUE: begin
                if (bus.uop_ready) begin
                    rem_n = rem_next_s;
                    if (rem_next_s == {NREGS{1'b0}}) begin
                        uop_valid_n = 1'b0;
                        uop_last_n  = 1'b0;
                        wb_valid_n  = wb_req_r;
                        state_n     = wb_req_r ? WB : IDLE;
                    end else begin
                        uop_reg_n  = lowest_idx(rem_next_s);
                        uop_addr_n = uop_addr_r + WORD_BYTES;
                        uop_last_n = one_left(rem_next_s);
                    end
                end else begin
                    state_n = ISSUE;
                end
            end
            WB: begin
                state_n = IDLE;
            end
            default: begin
                state_n     = IDLE;
                uop_valid_n = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any instruction in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            rem_r       <= {NREGS{1'b0}};
            wb_req_r    <= 1'b0;
            uop_valid_r <= 1'b0;
            uop_load_r  <= 1'b0;
            uop_reg_r   <= {REG_IDX_W{1'b0}};
            uop_addr_r  <= {ADDR_W{1'b0}};
            uop_last_r  <= 1'b0;
            wb_valid_r  <= 1'b0;
            wb_reg_r    <= {REG_IDX_W{1'b0}};
            wb_data_r   <= {ADDR_W{1'b0}};
        end else begin
            state_r     <= state_n;
            rem_r       <= rem_n;
            wb_req_r    <= wb_req_n;
            uop_valid_r <= uop_valid_n;
            uop_load_r  <= uop_load_n;
            uop_reg_r   <= uop_reg_n;
            uop_addr_r  <= uop_addr_n;
            uop_last_r  <= uop_last_n;
            wb_valid_r  <= wb_valid_n;
            wb_reg_r    <= wb_reg_n;
            wb_data_r   <= wb_data_n;
        end
    end

    assign bus.inst_ready = (state_r == IDLE);
    assign bus.busy       = (state_r != IDLE);
    assign bus.read_rn    = bus.inst[19:16];
    assign bus.uop_valid  = uop_valid_r;
    assign bus.uop_load   = uop_load_r;
    assign bus.uop_reg    = uop_reg_r;
    assign bus.uop_addr   = uop_addr_r;
    assign bus.uop_last   = uop_last_r;
    assign bus.wb_valid   = wb_valid_r;
    assign bus.wb_reg     = wb_reg_r;
    assign bus.wb_data    = wb_data_r;
endmodule

// File: tb/tb_arm_ldst_seq.sv
// Directed testbench for arm_ldst_seq: hand-encoded LDR/STR/LDM/STM vectors
// with hand-computed micro-op and writeback expectations.
module tb_arm_ldst_seq;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    arm_ldst_if #(.ADDR_W(32), .REG_IDX_W(4)) bus ();

    arm_ldst_seq #(.ADDR_W(32), .NREGS(16), .REG_IDX_W(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction for a single accept cycle, then scramble the inputs.
    task automatic offer(input logic [31:0] ins, input logic [31:0] rn, input logic cp);
        bus.inst       = ins;
        bus.rn_val     = rn;
        bus.cond_pass  = cp;
        bus.inst_valid = 1'b1;
        tick();
        bus.inst_valid = 1'b0;
        bus.inst       = 32'hE8BF_FFFF;
        bus.rn_val     = 32'hDEAD_BEEF;
        bus.cond_pass  = 1'b1;
    endtask

    task automatic expect_uop(input string tag, input logic ld, input logic [3:0] rg,
                              input logic [31:0] ad, input logic last);
        check_eq({tag, ".valid"}, {63'd0, bus.uop_valid}, 64'd1);
        check_eq({tag, ".load"},  {63'd0, bus.uop_load},  {63'd0, ld});
        check_eq({tag, ".reg"},   {60'd0, bus.uop_reg},   {60'd0, rg});
        check_eq({tag, ".addr"},  {32'd0, bus.uop_addr},  {32'd0, ad});
        check_eq({tag, ".last"},  {63'd0, bus.uop_last},  {63'd0, last});
        check_eq({tag, ".busy"},  {63'd0, bus.busy},      64'd1);
        tick();
    endtask

    task automatic expect_wb(input string tag, input logic [3:0] rg, input logic [31:0] dat);
        check_eq({tag, ".wb_valid"}, {63'd0, bus.wb_valid}, 64'd1);
        check_eq({tag, ".wb_reg"},   {60'd0, bus.wb_reg},   {60'd0, rg});
        check_eq({tag, ".wb_data"},  {32'd0, bus.wb_data},  {32'd0, dat});
        check_eq({tag, ".uop_idle"}, {63'd0, bus.uop_valid}, 64'd0);
        tick();
        check_eq({tag, ".wb_once"},  {63'd0, bus.wb_valid},  64'd0);
        check_eq({tag, ".ready"},    {63'd0, bus.inst_ready}, 64'd1);
    endtask

    task automatic expect_quiet(input string tag);
        check_eq({tag, ".uop_valid"}, {63'd0, bus.uop_valid},  64'd0);
        check_eq({tag, ".wb_valid"},  {63'd0, bus.wb_valid},   64'd0);
        check_eq({tag, ".busy"},      {63'd0, bus.busy},       64'd0);
        check_eq({tag, ".ready"},     {63'd0, bus.inst_ready}, 64'd1);
    endtask

    task automatic expect_all_zero(input string tag);
        check_eq({tag, ".uop_outs"},
                 {bus.uop_valid, bus.uop_load, bus.uop_last, bus.uop_reg, bus.uop_addr},
                 64'd0);
        check_eq({tag, ".wb_outs"}, {bus.wb_valid, bus.wb_reg, bus.wb_data}, 64'd0);
        check_eq({tag, ".busy"},    {63'd0, bus.busy},       64'd0);
        check_eq({tag, ".ready"},   {63'd0, bus.inst_ready}, 64'd1);
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst_n          = 1'b0;
        bus.inst_valid = 1'b0;
        bus.inst       = 32'd0;
        bus.cond_pass  = 1'b0;
        bus.rn_val     = 32'd0;
        bus.uop_ready  = 1'b1;
        tick();
        tick();
        expect_all_zero("reset");
        rst_n = 1'b1;
        tick();

        bus.inst = 32'hE5B3_1000;
        #1;
        check_eq("read_rn", {60'd0, bus.read_rn}, 64'd3);

        // LDMIA r0!,{r1,r3,r5}
        offer(32'hE8B0_002A, 32'h0000_1000, 1'b1);
        expect_uop("ldmia0", 1'b1, 4'd1, 32'h0000_1000, 1'b0);
        expect_uop("ldmia1", 1'b1, 4'd3, 32'h0000_1004, 1'b0);
        expect_uop("ldmia2", 1'b1, 4'd5, 32'h0000_1008, 1'b1);
        expect_wb("ldmia", 4'd0, 32'h0000_100C);

        // STMDB r13!,{r4,r14} with a three-cycle stall on the first uop
        bus.uop_ready = 1'b0;
        offer(32'hE92D_4010, 32'h0000_2000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check_eq("stall.reg",   {60'd0, bus.uop_reg},  64'd4);
            check_eq("stall.addr",  {32'd0, bus.uop_addr}, 64'h1FF8);
            check_eq("stall.valid", {bus.uop_valid, bus.uop_load, bus.uop_last}, {61'd0, 3'b100});
            tick();
        end
        bus.uop_ready = 1'b1;
        expect_uop("stmdb0", 1'b0, 4'd4,  32'h0000_1FF8, 1'b0);
        expect_uop("stmdb1", 1'b0, 4'd14, 32'h0000_1FFC, 1'b1);
        expect_wb("stmdb", 4'd13, 32'h0000_1FF8);

        // LDR r2,[r1,#-8]!
        offer(32'hE531_2008, 32'h0000_0100, 1'b1);
        expect_uop("ldr_pre", 1'b1, 4'd2, 32'h0000_00F8, 1'b1);
        expect_wb("ldr_pre", 4'd1, 32'h0000_00F8);
        // LDR r2,[r1],#8
        offer(32'hE491_2008, 32'h0000_0100, 1'b1);
        expect_uop("ldr_post", 1'b1, 4'd2, 32'h0000_0100, 1'b1);
        expect_wb("ldr_post", 4'd1, 32'h0000_0108);
        // LDR r2,[r1,#4]
        offer(32'hE591_2004, 32'h0000_0100, 1'b1);
        expect_uop("ldr_off", 1'b1, 4'd2, 32'h0000_0104, 1'b1);
        expect_quiet("ldr_off_nowb");

        // Condition failed LDM, then a data-processing op
        offer(32'hE8B0_002A, 32'h0000_1000, 1'b0);
        expect_quiet("cond_fail");
        offer(32'hE081_0002, 32'h0000_1000, 1'b1);
        expect_quiet("dp_op");
        tick();
        expect_quiet("dp_op_after");

        // LDMDB r0!,{r0,r1,r2} with wrap, base in list suppresses writeback
        offer(32'hE930_0007, 32'h0000_0004, 1'b1);
        expect_uop("ldmdb0", 1'b1, 4'd0, 32'hFFFF_FFF8, 1'b0);
        expect_uop("ldmdb1", 1'b1, 4'd1, 32'hFFFF_FFFC, 1'b0);
        expect_uop("ldmdb2", 1'b1, 4'd2, 32'h0000_0000, 1'b1);
        expect_quiet("ldmdb_nowb");

        // Reset after first uop of LDMIA r0!,{r1-r4}
        offer(32'hE8B0_001E, 32'h0000_3000, 1'b1);
        expect_uop("rst0", 1'b1, 4'd1, 32'h0000_3000, 1'b0);
        check_eq("rst1.addr", {32'd0, bus.uop_addr}, 64'h3004);
        rst_n = 1'b0;
        tick();
        expect_all_zero("mid_reset");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_quiet("post_reset");
        end

        // Empty-list STM
        offer(32'hE880_0000, 32'h0000_5000, 1'b1);
        expect_quiet("stm_empty");
        tick();
        expect_quiet("stm_empty_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
